// File: rtl/gol_pkg.sv
// Shared constants for the Game of Life neighbour address generator:
// neighbour count and the per-index dx/dy offsets, in row-major order
// around the cell.
package gol_pkg;

  localparam int NEIGHBOURS_CNT = 8;

  localparam logic signed [1:0] OFS_M1 = 2'sb11;
  localparam logic signed [1:0] OFS_Z0 = 2'sb00;
  localparam logic signed [1:0] OFS_P1 = 2'sb01;

  // index: 0      1       2       3       4       5       6       7
  localparam logic signed [1:0] NBR_DX [NEIGHBOURS_CNT] =
    '{OFS_M1, OFS_Z0, OFS_P1, OFS_M1, OFS_P1, OFS_M1, OFS_Z0, OFS_P1};
  localparam logic signed [1:0] NBR_DY [NEIGHBOURS_CNT] =
    '{OFS_M1, OFS_M1, OFS_M1, OFS_Z0, OFS_Z0, OFS_P1, OFS_P1, OFS_P1};

endpackage

// File: rtl/get_neighbours_address_if.sv
// Cell address in, neighbour address set out. The master drives the cell
// address and valid; the slave (the generator) drives the neighbour set.
interface get_neighbours_address_if
  import gol_pkg::*;
#(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);

  logic                  i_valid;
  logic [X_ADR_SIZE-1:0] i_cell_x_adr;
  logic [Y_ADR_SIZE-1:0] i_cell_y_adr;
  logic                  o_valid;
  logic [X_ADR_SIZE-1:0] o_nbrs_x_adr [NEIGHBOURS_CNT];
  logic [Y_ADR_SIZE-1:0] o_nbrs_y_adr [NEIGHBOURS_CNT];
  logic                  o_nbrs_rlvnt [NEIGHBOURS_CNT];

  modport master (
    output i_valid, i_cell_x_adr, i_cell_y_adr,
    input  o_valid, o_nbrs_x_adr, o_nbrs_y_adr, o_nbrs_rlvnt
  );

  modport slave (
    input  i_valid, i_cell_x_adr, i_cell_y_adr,
    output o_valid, o_nbrs_x_adr, o_nbrs_y_adr, o_nbrs_rlvnt
  );

endinterface

// File: rtl/nbr_offset_calc.sv
// One neighbour: cell address plus a -1/0/+1 offset (wrapping modulo the
// address width) and whether that neighbour lies inside the field.
module nbr_offset_calc #(
  parameter int FIELD_W    = 4,
  parameter int FIELD_H    = 3,
  parameter int X_ADR_SIZE = $clog2(FIELD_W),
  parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic [X_ADR_SIZE-1:0] cell_x,
  input  logic [Y_ADR_SIZE-1:0] cell_y,
  input  logic signed [1:0]     dx,
  input  logic signed [1:0]     dy,
  output logic [X_ADR_SIZE-1:0] nbr_x,
  output logic [Y_ADR_SIZE-1:0] nbr_y,
  output logic                  rlvnt
);

  // Sign-extending cast makes -1 wrap to all-ones, matching modulo arithmetic.
  assign nbr_x = cell_x + X_ADR_SIZE'(dx);
  assign nbr_y = cell_y + Y_ADR_SIZE'(dy);

  // Relevance: cell inside the field and the step does not cross an edge.
  always_comb begin
    logic in_field;
    logic x_ok;
    logic y_ok;
    in_field = (32'(cell_x) < FIELD_W) && (32'(cell_y) < FIELD_H);
    x_ok = 1'b1;
    y_ok = 1'b1;
    if (dx == 2'sb11)      x_ok = (cell_x != '0);
    else if (dx == 2'sb01) x_ok = (32'(cell_x) < FIELD_W - 1);
    if (dy == 2'sb11)      y_ok = (cell_y != '0);
    else if (dy == 2'sb01) y_ok = (32'(cell_y) < FIELD_H - 1);
    rlvnt = in_field && x_ok && y_ok;
  end

endmodule

// File: rtl/get_neighbours_address.sv
// Registered Moore-neighbourhood address generator, one cycle of latency.
// Addresses are produced every cycle regardless of i_valid; i_valid only
// travels alongside as o_valid.
module get_neighbours_address
  import gol_pkg::*;
#(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  get_neighbours_address_if.slave  bus
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);

  logic [X_ADR_SIZE-1:0] nbr_x     [NEIGHBOURS_CNT];
  logic [Y_ADR_SIZE-1:0] nbr_y     [NEIGHBOURS_CNT];
  logic                  nbr_rlvnt [NEIGHBOURS_CNT];

  for (genvar i = 0; i < NEIGHBOURS_CNT; i++) begin : g_nbr
    nbr_offset_calc #(
      .FIELD_W    (FIELD_W),
      .FIELD_H    (FIELD_H),
      .X_ADR_SIZE (X_ADR_SIZE),
      .Y_ADR_SIZE (Y_ADR_SIZE)
    ) u_calc (
      .cell_x (bus.i_cell_x_adr),
      .cell_y (bus.i_cell_y_adr),
      .dx     (NBR_DX[i]),
      .dy     (NBR_DY[i]),
      .nbr_x  (nbr_x[i]),
      .nbr_y  (nbr_y[i]),
      .rlvnt  (nbr_rlvnt[i])
    );
  end

  // Output register bank; reset clears everything so nothing in flight survives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid <= 1'b0;
      for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
        bus.o_nbrs_x_adr[i] <= '0;
        bus.o_nbrs_y_adr[i] <= '0;
        bus.o_nbrs_rlvnt[i] <= 1'b0;
      end
    end else begin
      bus.o_valid <= bus.i_valid;
      for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
        bus.o_nbrs_x_adr[i] <= nbr_x[i];
        bus.o_nbrs_y_adr[i] <= nbr_y[i];
        bus.o_nbrs_rlvnt[i] <= nbr_rlvnt[i];
      end
    end
  end

endmodule

// File: tb/tb_get_neighbours_address.sv
// Bench for get_neighbours_address on a 4x3 field. Expected neighbour sets
// are pushed when a cell is driven and compared one edge later.
module tb_get_neighbours_address;
  import gol_pkg::*;

  localparam int FW = 4;
  localparam int FH = 3;

  typedef struct {
    logic        v;
    logic [15:0] xs;
    logic [15:0] ys;
    logic [7:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];

  get_neighbours_address_if #(.FIELD_W(FW), .FIELD_H(FH)) bus ();

  get_neighbours_address #(.FIELD_W(FW), .FIELD_H(FH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input logic v);
    exp_t e;
    logic in_field;
    in_field = (x < FW) && (y < FH);
    e.v = v;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
      int nx;
      int ny;
      nx = x + int'(NBR_DX[i]);
      ny = y + int'(NBR_DY[i]);
      e.xs[2*i +: 2] = 2'(nx);
      e.ys[2*i +: 2] = 2'(ny);
      e.fl[i] = in_field && nx >= 0 && nx < FW && ny >= 0 && ny < FH;
    end
    return e;
  endfunction

  task automatic drive(input int x, input int y, input logic v, input int fl_exp = -1);
    exp_t e;
    @(negedge clk);
    bus.i_valid      = v;
    bus.i_cell_x_adr = 2'(x);
    bus.i_cell_y_adr = 2'(y);
    e = model(x, y, v);
    if (fl_exp >= 0) e.fl = 8'(fl_exp);
    sb.push_back(e);
  endtask

  function automatic logic [15:0] pack_x();
    logic [15:0] r;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) r[2*i +: 2] = bus.o_nbrs_x_adr[i];
    return r;
  endfunction

  function automatic logic [15:0] pack_y();
    logic [15:0] r;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) r[2*i +: 2] = bus.o_nbrs_y_adr[i];
    return r;
  endfunction

  function automatic logic [7:0] pack_fl();
    logic [7:0] r;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) r[i] = bus.o_nbrs_rlvnt[i];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_x"},     32'(pack_x()),    32'd0);
    check({tag, "_y"},     32'(pack_y()),    32'd0);
    check({tag, "_flags"}, 32'(pack_fl()),   32'd0);
  endtask

  // Scoreboard consumer: one expected set per rising edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      exp_t e;
      logic [7:0]  fl;
      logic [15:0] ys;
      logic        out_of_field;
      e  = sb.pop_front();
      fl = pack_fl();
      ys = pack_y();
      check("o_valid", 32'(bus.o_valid), 32'(e.v));
      check("flags",   32'(fl),          32'(e.fl));
      check("x_adr",   32'(pack_x()),    32'(e.xs));
      check("y_adr",   32'(ys),          32'(e.ys));
      out_of_field = 1'b0;
      for (int i = 0; i < NEIGHBOURS_CNT; i++)
        if (fl[i] && ys[2*i +: 2] >= 2'(FH)) out_of_field = 1'b1;
      check("rlvnt_in_field", 32'(out_of_field), 32'd0);
    end
  end

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_cell_x_adr = '0;
    bus.i_cell_y_adr = '0;

    // reset state
    @(posedge clk);
    #2;
    check_all_zero("por");

    // release; interior cell, corners, edges, out-of-field
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 1'b1, 8'hFF);
    drive(0, 0, 1'b1, 8'hD0);
    drive(3, 2, 1'b1, 8'h0B);
    drive(2, 0, 1'b1, 8'hF8);
    drive(3, 1, 1'b1, 8'h6B);
    drive(0, 3, 1'b1, 8'h00);
    drive(3, 3, 1'b0, 8'h00);

    // full sweep back-to-back
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        drive(x, y, 1'b1);

    // random cells with toggling valid
    for (int n = 0; n < 24; n++)
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // reset mid-stream: outputs clear without a clock edge
    drive(1, 1, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    @(negedge clk);
    bus.i_valid      = 1'b1;
    bus.i_cell_x_adr = 2'd2;
    bus.i_cell_y_adr = 2'd1;
    @(posedge clk);
    #2;
    check_all_zero("held_rst");

    // first output one cycle after the first sampled input
    @(negedge clk);
    rst = 1'b0;
    drive(2, 1, 1'b1, 8'hFF);
    drive(1, 2, 1'b0, 8'h1F);
    drive(0, 1, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
